// File: rtl/fpga2cpu_dma_mq.sv
// Multi-queue FPGA-to-CPU DMA: turns ring_buffer transfer requests into WRDM descriptors.
// Optional FPGA2CPU_MQ_WAIT_DONE_EN: hold completion until WRDM has read the last slot.
//
// state     | meaning
// IDLE      | ready for a request
// CHECK     | validate size, wait for CPU ring space
// DESC_LO   | data descriptor up to ring end (or whole transfer)
// DESC_HI   | wrapped remainder, starting at ring slot 0
// DONE      | publish new tail to host memory
// WAIT      | wait for WRDM to read the last FPGA slot
module fpga2cpu_dma_mq #(
  parameter int          NUM_Q          = 4,
  parameter int          RB_AWIDTH      = 12,
  parameter int          PDU_AWIDTH     = 12,
  parameter int          RB_BRAM_OFFSET = 0,
  parameter logic [31:0] EP_BASE_ADDR   = 32'h0004_0000,
  parameter logic [7:0]  DONE_ID        = 8'hFE,
  localparam int         QW             = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [QW-1:0]              req_qid,
  input  logic [PDU_AWIDTH-1:0]      req_size,
  input  logic [PDU_AWIDTH-1:0]      req_base_addr,
  input  logic [NUM_Q*RB_AWIDTH-1:0] head,
  input  logic [NUM_Q*64-1:0]        kmem_addr,
  input  logic [NUM_Q*31-1:0]        rb_size,
  output logic [NUM_Q*RB_AWIDTH-1:0] out_tail,
  output logic                       wrdm_desc_valid,
  input  logic                       wrdm_desc_ready,
  output logic [173:0]               wrdm_desc_data,
  input  logic                       frb_read,
  input  logic [PDU_AWIDTH-1:0]      frb_address,
  input  logic                       frb_readvalid,
  output logic                       dma_done,
  output logic [QW-1:0]              dma_done_qid,
  output logic                       req_err
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DESC_LO, S_DESC_HI, S_DONE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [QW-1:0]         q_q;
  logic [PDU_AWIDTH-1:0] size_q, base_q;
  logic [RB_AWIDTH-1:0]  t_q;
  logic [31:0]           r_q;
  logic [63:0]           kmem_q;
  logic                  wrap_q;
  logic [RB_AWIDTH-1:0]  tail_q [NUM_Q];

  int          qi;
  logic [31:0] t_cur, h_cur, r_cur, size32, free_cur;
  logic        bad, fits, wrap_cur;

  assign qi = int'(q_q);

  // Space check runs on live head so a blocked request sees the consumer advance.
  always_comb begin
    t_cur    = 32'(tail_q[q_q]);
    h_cur    = 32'(head[qi*RB_AWIDTH +: RB_AWIDTH]);
    r_cur    = 32'(rb_size[qi*31 +: 31]);
    size32   = 32'(size_q);
    free_cur = (t_cur >= h_cur) ? r_cur - t_cur + h_cur - 32'd1 : h_cur - t_cur - 32'd1;
    bad      = (size32 == 32'd0) || (size32 > r_cur - 32'd1);
    fits     = free_cur >= size32;
    wrap_cur = (t_cur + size32) > r_cur;
  end

  logic [31:0]          t32, first_len, second_len, src_lo, src_hi, new_tail32;
  logic [63:0]          dst_lo, dst_hi;
  logic [RB_AWIDTH-1:0] new_tail;

  always_comb begin
    t32        = 32'(t_q);
    first_len  = wrap_q ? r_q - t32 : 32'(size_q);
    second_len = 32'(size_q) - (r_q - t32);
    src_lo     = EP_BASE_ADDR + ((32'(RB_BRAM_OFFSET) + 32'(base_q)) << 6);
    src_hi     = src_lo + ((r_q - t32) << 6);
    dst_lo     = kmem_q + (64'(t32 + 32'd1) << 6);
    dst_hi     = kmem_q + 64'd64;
    new_tail32 = (t32 + 32'(size_q) >= r_q) ? t32 + 32'(size_q) - r_q : t32 + 32'(size_q);
    new_tail   = RB_AWIDTH'(new_tail32);
  end

  function automatic logic [173:0] data_desc(input logic [31:0] len, input logic [63:0] dst,
                                             input logic [31:0] src);
    logic [17:0] len_field;
    len_field = 18'(len << 4);
    return {14'h0, 14'h0, len_field, dst, 32'h0, src};
  endfunction

  logic wait_exit, done_fire, unused_frb;

`ifdef FPGA2CPU_MQ_WAIT_DONE_EN
  // WRDM read data returns two cycles after the address, so compare the delayed address.
  logic [PDU_AWIDTH-1:0] addr_d1, addr_d2, last_addr;
  assign last_addr = base_q + size_q - PDU_AWIDTH'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_d1 <= '0;
      addr_d2 <= '0;
    end else begin
      addr_d1 <= frb_address;
      addr_d2 <= addr_d1;
    end
  end
  assign wait_exit  = frb_readvalid && (addr_d2 == last_addr);
  assign done_fire  = (state_q == S_WAIT) && wait_exit;
  assign unused_frb = frb_read;
`else
  assign wait_exit  = 1'b1;
  assign done_fire  = (state_q == S_DONE) && wrdm_desc_ready;
  assign unused_frb = ^{frb_read, frb_readvalid, frb_address};
`endif

  always_comb begin
    state_d         = state_q;
    wrdm_desc_valid = 1'b0;
    wrdm_desc_data  = '0;
    case (state_q)
      S_IDLE:  if (req_valid && req_ready) state_d = S_CHECK;
      S_CHECK: begin
        if (bad)       state_d = S_IDLE;
        else if (fits) state_d = S_DESC_LO;
      end
      S_DESC_LO: begin
        wrdm_desc_valid = 1'b1;
        wrdm_desc_data  = data_desc(first_len, dst_lo, src_lo);
        if (wrdm_desc_ready) state_d = wrap_q ? S_DESC_HI : S_DONE;
      end
      S_DESC_HI: begin
        wrdm_desc_valid = 1'b1;
        wrdm_desc_data  = data_desc(second_len, dst_hi, src_hi);
        if (wrdm_desc_ready) state_d = S_DONE;
      end
      S_DONE: begin
        wrdm_desc_valid = 1'b1;
        wrdm_desc_data  = {14'h0, DONE_ID, 3'b0, 1'b0, 1'b0, 1'b1, 18'd1, kmem_q, 32'h0,
                           32'(new_tail)};
        if (wrdm_desc_ready) begin
`ifdef FPGA2CPU_MQ_WAIT_DONE_EN
          state_d = S_WAIT;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_WAIT:  if (wait_exit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready    <= 1'b0;
      q_q          <= '0;
      size_q       <= '0;
      base_q       <= '0;
      t_q          <= '0;
      r_q          <= '0;
      kmem_q       <= '0;
      wrap_q       <= 1'b0;
      dma_done     <= 1'b0;
      dma_done_qid <= '0;
      req_err      <= 1'b0;
      for (int i = 0; i < NUM_Q; i++) tail_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == S_IDLE);
      req_err   <= (state_q == S_CHECK) && bad;
      dma_done  <= done_fire;
      if (done_fire) dma_done_qid <= q_q;
      if (state_q == S_IDLE && req_valid && req_ready) begin
        q_q    <= req_qid;
        size_q <= req_size;
        base_q <= req_base_addr;
      end
      // Snapshot ring parameters so descriptors stay stable while stalled.
      if (state_q == S_CHECK) begin
        t_q    <= tail_q[q_q];
        r_q    <= r_cur;
        kmem_q <= kmem_addr[qi*64 +: 64];
        wrap_q <= wrap_cur;
      end
      if (state_q == S_DONE && wrdm_desc_ready) tail_q[q_q] <= new_tail;
    end
  end

  for (genvar g = 0; g < NUM_Q; g++) begin : g_tail
    assign out_tail[g*RB_AWIDTH +: RB_AWIDTH] = tail_q[g];
  end

endmodule

// File: tb/tb_fpga2cpu_dma_mq.sv
// Scoreboard bench for fpga2cpu_dma_mq: ring model predicts descriptors, tails and completions.
`timescale 1ns/1ps
module tb_fpga2cpu_dma_mq;
  localparam int NUM_Q = 4;
  localparam int RBW   = 12;
  localparam int PAW   = 12;
  localparam logic [31:0] EP = 32'h0004_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready;
  logic [1:0] req_qid;
  logic [PAW-1:0] req_size, req_base_addr;
  logic [NUM_Q*RBW-1:0] head, out_tail;
  logic [NUM_Q*64-1:0] kmem_addr;
  logic [NUM_Q*31-1:0] rb_size;
  logic wrdm_desc_valid, wrdm_desc_ready;
  logic [173:0] wrdm_desc_data;
  logic frb_read, frb_readvalid;
  logic [PAW-1:0] frb_address;
  logic dma_done, req_err;
  logic [1:0] dma_done_qid;

  always #5 clk = ~clk;

  fpga2cpu_dma_mq #(
    .NUM_Q(NUM_Q), .RB_AWIDTH(RBW), .PDU_AWIDTH(PAW), .RB_BRAM_OFFSET(0),
    .EP_BASE_ADDR(EP), .DONE_ID(8'hFE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_qid(req_qid),
    .req_size(req_size), .req_base_addr(req_base_addr),
    .head(head), .kmem_addr(kmem_addr), .rb_size(rb_size), .out_tail(out_tail),
    .wrdm_desc_valid(wrdm_desc_valid), .wrdm_desc_ready(wrdm_desc_ready),
    .wrdm_desc_data(wrdm_desc_data),
    .frb_read(frb_read), .frb_address(frb_address), .frb_readvalid(frb_readvalid),
    .dma_done(dma_done), .dma_done_qid(dma_done_qid), .req_err(req_err)
  );

  typedef struct { logic [173:0] d; bit is_done; int base; int size; } exp_t;
  typedef struct { int base; int size; } job_t;

  int checks = 0;
  int failures = 0;
  exp_t exp_desc[$];
  int   exp_done[$];
  int   exp_err = 0;
  job_t jobs[$];
  bit   emu_busy = 0;
  int   ready_mode = 0;

  int model_tail[NUM_Q];
  int rsz[NUM_Q];
  int head_m[NUM_Q];
  longint unsigned kmem_m[NUM_Q];

  task automatic chk(string name, logic [173:0] act, logic [173:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [173:0] mk_data(int len, longint unsigned dst, logic [31:0] src);
    return {14'h0, 14'h0, 18'(len * 16), 64'(dst), 32'h0, src};
  endfunction

  function automatic logic [173:0] mk_done(longint unsigned km, int nt);
    return {14'h0, 8'hFE, 6'b000001, 18'd1, 64'(km), 32'h0, 32'(nt)};
  endfunction

  task automatic apply_cfg();
    for (int q = 0; q < NUM_Q; q++) begin
      head[q*RBW +: RBW]    = RBW'(head_m[q]);
      kmem_addr[q*64 +: 64] = kmem_m[q];
      rb_size[q*31 +: 31]   = 31'(rsz[q]);
    end
  endtask

  task automatic push_desc(logic [173:0] d, bit is_done, int base, int size);
    exp_t e;
    e.d = d; e.is_done = is_done; e.base = base; e.size = size;
    exp_desc.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_desc.size() != 0 || exp_done.size() != 0 || exp_err != 0 ||
            jobs.size() != 0 || emu_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 174'(n < 4000), 174'(1));
    repeat (2) @(negedge clk);
    for (int q = 0; q < NUM_Q; q++)
      chk($sformatf("out_tail_q%0d", q), 174'(out_tail[q*RBW +: RBW]), 174'(model_tail[q]));
  endtask

  // Model: a transfer of `size` slots lands at ring slots t..t+size-1 (mod R); host slot s
  // lives at kmem + 64*(s+1), and each chunk reads FPGA slots from base onward.
  task automatic do_req(int q, int size, int base, bit wait_done);
    int t, r, l1;
    bit ok;
    longint unsigned km;
    t = model_tail[q]; r = rsz[q]; km = kmem_m[q];
    if (size == 0 || size > r - 1) exp_err++;
    else begin
      if (t + size > r) begin
        l1 = r - t;
        push_desc(mk_data(l1, km + 64 * (t + 1), 32'(EP + base * 64)), 0, 0, 0);
        push_desc(mk_data(size - l1, km + 64, 32'(EP + (base + l1) * 64)), 0, 0, 0);
      end else begin
        push_desc(mk_data(size, km + 64 * (t + 1), 32'(EP + base * 64)), 0, 0, 0);
      end
      model_tail[q] = (t + size) % r;
      push_desc(mk_done(km, model_tail[q]), 1, base, size);
      exp_done.push_back(q);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_qid = 2'(q); req_size = PAW'(size); req_base_addr = PAW'(base);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    chk("req_accept", 174'(ok), 174'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  // Ready driver
  initial begin
    wrdm_desc_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       wrdm_desc_ready = ($urandom_range(0, 3) != 0);
        1:       wrdm_desc_ready = 1'b0;
        default: wrdm_desc_ready = 1'b1;
      endcase
    end
  end

  // WRDM read-port emulator: read data returns two cycles after each address.
  initial begin
    job_t j;
    frb_read = 1'b0; frb_address = '0; frb_readvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (jobs.size() > 0 && rst_n) begin
        j = jobs.pop_front();
        emu_busy = 1;
        for (int k = 0; k < j.size + 2; k++) begin
          frb_read      = (k < j.size);
          frb_address   = PAW'(j.base + k);
          frb_readvalid = (k >= 2);
          @(posedge clk); #1;
        end
        frb_read = 1'b0; frb_readvalid = 1'b0;
        emu_busy = 0;
      end
    end
  end

  // Monitor / scoreboard
  bit prev_stall = 0;
  logic [173:0] prev_data;
  exp_t e_mon;
  job_t j_mon;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", 174'(wrdm_desc_valid), 174'(1));
        chk("hold_data", wrdm_desc_data, prev_data);
      end
      prev_stall = wrdm_desc_valid && !wrdm_desc_ready;
      prev_data  = wrdm_desc_data;
      if (wrdm_desc_valid && wrdm_desc_ready) begin
        if (exp_desc.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_desc: got %0h expected none", wrdm_desc_data);
        end else begin
          e_mon = exp_desc.pop_front();
          chk("desc", wrdm_desc_data, e_mon.d);
          if (e_mon.is_done) begin
            j_mon.base = e_mon.base; j_mon.size = e_mon.size;
            jobs.push_back(j_mon);
          end
        end
      end
      if (dma_done) begin
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_dma_done: got qid %0d expected none", dma_done_qid);
        end else chk("dma_done_qid", 174'(dma_done_qid), 174'(exp_done.pop_front()));
      end
      if (req_err) begin
        if (exp_err == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req_err: got 1 expected 0");
        end else begin
          checks++;
          exp_err--;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, 174'(req_ready), 174'(0));
    chk({tag, "_desc_valid"}, 174'(wrdm_desc_valid), 174'(0));
    chk({tag, "_desc_data"}, wrdm_desc_data, 174'(0));
    chk({tag, "_out_tail"}, 174'(out_tail), 174'(0));
    chk({tag, "_dma_done"}, 174'(dma_done), 174'(0));
    chk({tag, "_dma_done_qid"}, 174'(dma_done_qid), 174'(0));
    chk({tag, "_req_err"}, 174'(req_err), 174'(0));
  endtask

  initial begin
    int n, sz, used, q, r;
    req_valid = 0; req_qid = 0; req_size = 0; req_base_addr = 0;
    head = '0; kmem_addr = '0; rb_size = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      rsz[i] = 16; head_m[i] = 0; model_tail[i] = 0;
      kmem_m[i] = {$urandom, $urandom};
    end
    apply_cfg();
    #1;
    check_reset_outputs("reset");
    #20 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", 174'(req_ready), 174'(1));

    // Single descriptor plus latency: CHECK at cycle 1, first descriptor at cycle 2.
    do_req(0, 4, 8, 0);
    @(negedge clk);
    chk("lat_check_no_valid", 174'(wrdm_desc_valid), 174'(0));
    @(negedge clk);
    chk("lat_first_desc_valid", 174'(wrdm_desc_valid), 174'(1));
    wait_idle();

    // Wrap: q2 tail to 14, then size 5 splits 2 + 3.
    do_req(2, 14, 200, 1);
    head_m[2] = 14; apply_cfg();
    do_req(2, 5, 300, 1);

    // Exact fit to ring end: single descriptor, tail returns to 0.
    do_req(3, 12, 40, 1);
    head_m[3] = 12; apply_cfg();
    do_req(3, 4, 4093, 1);

    // t+size == R+1: second descriptor of length 1.
    head_m[0] = 4; apply_cfg();
    do_req(0, 13, 17, 1);

    // Head-of-line block until head advances.
    head_m[1] = 3; apply_cfg();
    do_req(1, 3, 50, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("blocked_no_valid", 174'(wrdm_desc_valid), 174'(0));
    end
    head_m[1] = 4; apply_cfg();
    wait_idle();

    // Dropped requests.
    do_req(0, 0, 5, 1);
    do_req(0, 16, 5, 1);

    // Long stall: valid and data must hold.
    ready_mode = 1;
    head_m[1] = model_tail[1]; apply_cfg();
    do_req(1, 7, 123, 0);
    repeat (10) @(posedge clk);
    ready_mode = 0;
    wait_idle();

    // Reset while DESC_HI is presented.
    ready_mode = 1;
    head_m[2] = model_tail[2]; apply_cfg();
    do_req(2, 16 - model_tail[2] + 1, 100, 0);
    for (int i = 0; i < 50; i++) begin
      if (wrdm_desc_valid) break;
      @(negedge clk);
    end
    chk("rst_lo_valid", 174'(wrdm_desc_valid), 174'(1));
    @(posedge clk); #1 ready_mode = 2;
    @(posedge clk); #1 ready_mode = 1;
    @(negedge clk);
    chk("rst_hi_valid", 174'(wrdm_desc_valid), 174'(1));
    if (exp_desc.size() > 0) chk("rst_hi_data", wrdm_desc_data, exp_desc[0].d);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_desc.delete(); exp_done.delete(); jobs.delete(); exp_err = 0;
    for (int i = 0; i < NUM_Q; i++) model_tail[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_reissue_after_reset", 174'(wrdm_desc_valid), 174'(0));
    end

    // Randomized traffic over random ring sizes.
    for (int i = 0; i < NUM_Q; i++) begin
      rsz[i] = $urandom_range(2, 80);
      kmem_m[i] = {$urandom, $urandom};
      head_m[i] = 0;
    end
    apply_cfg();
    for (int it = 0; it < 30; it++) begin
      q = $urandom_range(0, NUM_Q - 1);
      r = rsz[q];
      sz = $urandom_range(0, r);
      if (sz >= 1 && sz <= r - 1) begin
        used = $urandom_range(0, r - 1 - sz);
        head_m[q] = (model_tail[q] - used + r) % r;
      end
      apply_cfg();
      do_req(q, sz, $urandom_range(0, 4095), 1);
    end

    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga2cpu_dma_mq.md
# fpga2cpu_dma_mq

Multi-queue successor of the single-ring FPGA-to-CPU PCIe DMA engine. It takes transfer requests from the FPGA-side packet ring buffer and writes each one into one of NUM_Q CPU ring buffers through the PCIe write data mover. For each request it issues one data descriptor, or two when the CPU ring wraps, followed by an immediate "done" descriptor that publishes the new tail to host memory. It sits between ring_buffer and the WRDM descriptor port.

## Interface
- NUM_Q, 4: number of CPU ring buffers; QW = max(1, $clog2(NUM_Q)).
- RB_AWIDTH, 12: CPU ring index width, in 64-byte slots.
- PDU_AWIDTH, 12: FPGA ring address width, in 64-byte slots.
- RB_BRAM_OFFSET, 0: slot offset of the data BRAM inside the endpoint window.
- EP_BASE_ADDR, 32'h0004_0000: Avalon-MM base of the endpoint window.
- DONE_ID, 8'hFE: descriptor ID of done descriptors.
- clk in 1: clock.
- rst_n in 1: asynchronous, active-low reset.
- req_valid / req_ready in/out 1: request handshake.
- req_qid in QW: target queue.
- req_size in PDU_AWIDTH: transfer length in slots.
- req_base_addr in PDU_AWIDTH: FPGA ring start slot.
- head in NUM_Q*RB_AWIDTH: per-queue CPU head (queue q at [q*RB_AWIDTH +: RB_AWIDTH]).
- kmem_addr in NUM_Q*64: per-queue host base address.
- rb_size in NUM_Q*31: per-queue ring size in slots.
- out_tail out NUM_Q*RB_AWIDTH: per-queue tail.
- wrdm_desc_valid out 1, wrdm_desc_ready in 1, wrdm_desc_data out 174: descriptor stream.
- frb_read in 1, frb_address in PDU_AWIDTH, frb_readvalid in 1: WRDM read-port monitor.
- dma_done out 1, dma_done_qid out QW: completion pulse and its queue.
- req_err out 1: one-cycle pulse when a request is dropped.

## Operation
- FSM states: IDLE, CHECK, DESC_LO, DESC_HI, DONE, WAIT.
- IDLE: req_ready=1. On req_valid, latch qid, size and base, then go to CHECK.
- CHECK: t = out_tail[q], h = head[q], R = rb_size[q].
  - Drop the request (req_err pulse, return to IDLE) if size == 0 or size > R-1.
  - free = (t >= h) ? R-t+h-1 : h-t-1. Stay in CHECK until free >= size; head-of-line blocking is intended.
  - wrap = (t+size > R). Then go to DESC_LO.
- DESC_LO: present the data descriptor. Fields, MSB to LSB:
  - 14'h0, zero pad, length field = {len,4'b0} occupying the 18-bit dword count,
  - dst = kmem_addr[q] + 64*(t+1),
  - 32'h0, src = EP_BASE_ADDR + ((RB_BRAM_OFFSET+base) << 6), computed with explicit grouping.
  - len = wrap ? R-t : size.
  - On handshake, go to DESC_HI if wrap, else DONE.
- DESC_HI: len = size-(R-t), dst = kmem_addr[q]+64, src = previous src + ((R-t) << 6). On handshake, go to DONE.
- DONE: descriptor = {14'h0, DONE_ID, 3'b0, 1'b0, 1'b0, 1'b1, 18'd1, kmem_addr[q], 32'h0, zero-padded new_tail}.
  - new_tail = (t+size >= R) ? t+size-R : t+size.
  - On handshake, out_tail[q] <= new_tail and go to WAIT.
- WAIT: completes when frb_readvalid=1 and frb_address delayed by 2 cycles == base+size-1 (mod 2^PDU_AWIDTH). Then pulse dma_done with dma_done_qid=q and go to IDLE.
- Arithmetic: all ring arithmetic is done in 32 bits and truncated to RB_AWIDTH; the length field is 18 bits.

## Timing
- Reset values: req_ready=0 during reset, then 1 in IDLE; wrdm_desc_valid=0, wrdm_desc_data=0, out_tail all 0, dma_done=0, dma_done_qid=0, req_err=0, state IDLE.
- Descriptor handshake: a descriptor transfers on a cycle with valid && ready. Valid and data are held stable until that cycle, and valid drops the cycle after the last transfer unless the next descriptor is presented back-to-back.
- Latency: request accepted at cycle 0, CHECK at cycle 1, first descriptor valid at cycle 2 when space is available.
- Boundaries:
  - t+size == R: single descriptor, new_tail=0.
  - t+size == R+1: two descriptors, the second with len=1.
  - head changing while blocked in CHECK is re-evaluated every cycle.
- Reset asserted mid-transfer aborts immediately. No descriptor is re-issued after reset.

## Configuration
- FPGA2CPU_MQ_WAIT_DONE_EN defined: WAIT behaves as described in Operation.
- Undefined: WAIT is skipped. dma_done pulses on the done-descriptor handshake and the FSM returns to IDLE, so the next request can start while WRDM is still reading. The frb_* ports are ignored.

## Test plan
- q=0, R=16, t=0, h=0, size=4, base=8: one descriptor with dst=kmem+64 and src=0x40000+(8<<6) -> done immediate tail=4; out_tail[0]=4; dma_done after the read of address 11.
- q=2, R=16, t=14, size=5: low descriptor len=2 with dst=kmem+64*15 -> high descriptor len=3 with dst=kmem+64 and src advanced by 128 -> tail=3.
- R=16, t=12, size=4: exactly one descriptor, new_tail=0.
- h=3, t=0, R=16, size=3: blocked in CHECK (free=2) until head moves to 4, then proceeds; no descriptor is valid while blocked.
- size=0 and size=16 with R=16: req_err pulse, no descriptors, out_tail unchanged.
- wrdm_desc_ready held low for 10 cycles: valid and data stay constant. rst_n asserted in DESC_HI: all outputs reach their reset values asynchronously.
